// File: rtl/cascade_down_counter.sv
// Loadable, cascadable binary down-counter with borrow-out, terminal-count pulse and sticky underflow.
// Optional auto-reload on underflow: define CASCADE_DOWN_COUNTER_AUTO_RELOAD_EN.
module cascade_down_counter #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             en,
  input  logic             inh,
  input  logic             bin,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             bout,
  output logic             tc_pulse,
  output logic             uflow
);

  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] wrap_val_s;
  logic             tc_q, tc_d;
  logic             uflow_q, uflow_d;
  logic             cnt_act_s;
  logic             at_zero_s;

  assign cnt_act_s = en & ~inh & bin;
  assign at_zero_s = (cnt_q == {WIDTH{1'b0}});

`ifdef CASCADE_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] rl_q, rl_d;

  // reload register tracks the last loaded value
  always_comb begin
    rl_d = rl_q;
    if (ld) begin
      rl_d = ld_data;
    end else begin
      rl_d = rl_q;
    end
  end

  // reload register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rl_q <= RESET_VALUE;
    end else begin
      rl_q <= rl_d;
    end
  end

  assign wrap_val_s = rl_q;
`else
  assign wrap_val_s = ALL_ONES;
`endif

  // next-state: load beats count beats hold; a count at zero is an underflow
  always_comb begin
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    uflow_d = uflow_q;
    if (ld) begin
      cnt_d   = ld_data;
      uflow_d = 1'b0;
      tc_d    = 1'b0;
    end else if (cnt_act_s) begin
      if (at_zero_s) begin
        cnt_d   = wrap_val_s;
        uflow_d = 1'b1;
        tc_d    = 1'b1;
      end else begin
        cnt_d   = cnt_q - CNT_ONE;
        uflow_d = uflow_q;
        tc_d    = 1'b0;
      end
    end else begin
      cnt_d   = cnt_q;
      uflow_d = uflow_q;
      tc_d    = 1'b0;
    end
  end

  // counter, pulse and flag state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= RESET_VALUE;
      tc_q    <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      uflow_q <= uflow_d;
    end
  end

  // borrow-out is combinational so a chain ripples within one cycle
  assign bout     = cnt_act_s & at_zero_s;
  assign zero     = at_zero_s;
  assign q        = cnt_q;
  assign tc_pulse = tc_q;
  assign uflow    = uflow_q;

endmodule

// File: tb/tb_cascade_down_counter.sv
// Two cascaded stages driven with directed and random stimulus; a queue-based scoreboard
// checks every cycle against an arithmetic reference model.
module tb_cascade_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld = 1'b0, en = 1'b0, inh = 1'b0, bin = 1'b0;
  logic [7:0] d_lo = 8'h00, d_hi = 8'h00;
  logic [7:0] q_lo, q_hi;
  logic       zero_lo, zero_hi, bout_lo, bout_hi, tc_lo, tc_hi, uf_lo, uf_hi;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] q_lo, q_hi;
    logic       zero_lo, zero_hi, bout_lo, bout_hi, tc_lo, tc_hi, uf_lo, uf_hi;
  } exp_t;
  exp_t sb[$];

  // reference model state per stage (0 = low, 1 = high)
  int m_q[2];
  int m_rl[2];
  bit m_tc[2];
  bit m_uf[2];
  int rst_val[2];

  always #5 clk = ~clk;

  cascade_down_counter #(.WIDTH(8), .RESET_VALUE(8'h00)) u_lo (
    .clk(clk), .rst(rst), .ld(ld), .ld_data(d_lo), .en(en), .inh(inh), .bin(bin),
    .q(q_lo), .zero(zero_lo), .bout(bout_lo), .tc_pulse(tc_lo), .uflow(uf_lo)
  );

  cascade_down_counter #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_hi (
    .clk(clk), .rst(rst), .ld(ld), .ld_data(d_hi), .en(en), .inh(inh), .bin(bout_lo),
    .q(q_hi), .zero(zero_hi), .bout(bout_hi), .tc_pulse(tc_hi), .uflow(uf_hi)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int reload_of(input int i);
`ifdef CASCADE_DOWN_COUNTER_AUTO_RELOAD_EN
    return m_rl[i];
`else
    return 255;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_q[i]  = rst_val[i];
      m_rl[i] = rst_val[i];
      m_tc[i] = 1'b0;
      m_uf[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit l, input int data, input bit act);
    if (l) begin
      m_q[i]  = data;
      m_rl[i] = data;
      m_uf[i] = 1'b0;
      m_tc[i] = 1'b0;
    end else if (act) begin
      if (m_q[i] == 0) begin
        m_q[i]  = reload_of(i);
        m_uf[i] = 1'b1;
        m_tc[i] = 1'b1;
      end else begin
        m_q[i]  = m_q[i] - 1;
        m_tc[i] = 1'b0;
      end
    end else begin
      m_tc[i] = 1'b0;
    end
  endtask

  // one cycle: drive inputs just after the edge, queue what the DUT should show this cycle
  task automatic drive(input bit r, input bit l, input int dl, input int dh,
                       input bit e, input bit ih, input bit b);
    exp_t x;
    bit   act0, act1, bo0, bo1;
    @(posedge clk);
    #2;
    rst = r; ld = l; d_lo = 8'(dl); d_hi = 8'(dh); en = e; inh = ih; bin = b;
    if (r) model_reset();
    act0 = e && !ih && b;
    bo0  = act0 && (m_q[0] == 0);
    act1 = e && !ih && bo0;
    bo1  = act1 && (m_q[1] == 0);
    x.q_lo = 8'(m_q[0]);  x.q_hi = 8'(m_q[1]);
    x.zero_lo = (m_q[0] == 0); x.zero_hi = (m_q[1] == 0);
    x.bout_lo = bo0; x.bout_hi = bo1;
    x.tc_lo = m_tc[0]; x.tc_hi = m_tc[1];
    x.uf_lo = m_uf[0]; x.uf_hi = m_uf[1];
    sb.push_back(x);
    if (!r) begin
      model_step(0, l, dl, act0);
      model_step(1, l, dh, act1);
    end
  endtask

  // monitor: compare outputs mid-cycle against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q_lo",    q_lo,           e.q_lo);
      chk("q_hi",    q_hi,           e.q_hi);
      chk("zero_lo", {7'd0, zero_lo}, {7'd0, e.zero_lo});
      chk("zero_hi", {7'd0, zero_hi}, {7'd0, e.zero_hi});
      chk("bout_lo", {7'd0, bout_lo}, {7'd0, e.bout_lo});
      chk("bout_hi", {7'd0, bout_hi}, {7'd0, e.bout_hi});
      chk("tc_lo",   {7'd0, tc_lo},   {7'd0, e.tc_lo});
      chk("tc_hi",   {7'd0, tc_hi},   {7'd0, e.tc_hi});
      chk("uf_lo",   {7'd0, uf_lo},   {7'd0, e.uf_lo});
      chk("uf_hi",   {7'd0, uf_hi},   {7'd0, e.uf_hi});
    end
  end

  initial begin
    rst_val[0] = 0;
    rst_val[1] = 'hA5;
    model_reset();

    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // load 3 then count through underflow
    drive(1'b0, 1'b1, 3, 2, 1'b0, 1'b0, 1'b1);
    repeat (5) drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // inhibit overrides enable
    drive(1'b0, 1'b1, 5, 9, 1'b0, 1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1);

    // load wins over an underflowing count
    drive(1'b0, 1'b1, 0, 7, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 'h10, 7, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // cascade: low = 0, high = 2, then 1 + 256 counting cycles
    drive(1'b0, 1'b1, 0, 2, 1'b0, 1'b0, 1'b0);
    repeat (257) drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

    // asynchronous reset while a terminal-count pulse is high
    drive(1'b0, 1'b1, 1, 4, 1'b0, 1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);

`ifdef CASCADE_DOWN_COUNTER_AUTO_RELOAD_EN
    // reload value zero: stays at zero and underflows every active cycle
    drive(1'b0, 1'b1, 0, 3, 1'b0, 1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
`endif

    for (int n = 0; n < 400; n++) begin
      bit r, l, e, ih, b;
      int dl, dh;
      r  = ($urandom_range(0, 59) == 0);
      l  = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 7) != 0);
      ih = ($urandom_range(0, 7) == 0);
      b  = ($urandom_range(0, 7) != 0);
      dl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      dh = int'($urandom_range(0, 3));
      drive(r, l, dl, dh, e, ih, b);
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
